coalescing_write_buffer: RTL and testbench
==========================================

# coalescing_write_buffer

Parametrised, coalescing line-granular write buffer between the L1 data cache write path and the memory request port. Cache word writes are merged into per-line entries carrying a word mask, so a line that is already queued does not need a new entry. Entries drain in FIFO order over a valid/ready memory handshake. Reads check and forward the youngest buffered copy of a word.

## Interface
- `DEPTH`, 16: number of line entries; power of two, at least 2.
- `WORDS`, 4: words per line; power of two, at least 2.
- `ADDR_W`, 32: word-address width.
- `DATA_W`, 32: word width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cache_req_valid` in 1: word write offered.
- `cache_req_ready` out 1: write accepted this cycle if high.
- `cache_req_addr` in ADDR_W: word address.
  - Low log2(WORDS) bits select the word in the line.
  - The remaining upper bits are the line tag.
- `cache_req_data` in DATA_W: write data.
- `read_check` in 1: forwarding lookup enable.
- `read_addr` in ADDR_W: word address to look up.
- `read_hit` out 1: buffered copy of that word exists.
- `read_data` out DATA_W: forwarded word; 0 when there is no hit.
- `mem_req_valid` out 1: head entry presented.
- `mem_req_ready` in 1: memory accepts the head entry.
- `mem_req_addr` out ADDR_W: line base address; word bits are 0.
- `mem_req_data` out WORDS*DATA_W: line data; word i sits at bits [i*DATA_W +: DATA_W].
- `mem_req_mask` out WORDS: valid-word mask.
- `count` out $clog2(DEPTH+1): number of occupied entries.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.

## Operation
- **Storage:** circular queue with head, tail and count pointers. Each entry holds a tag, WORDS data words and a WORDS-bit mask.
- **Match:** the write tag is compared against occupied non-head entries only (head+1 .. tail-1). The head is frozen while it is presented to memory.
- **Invariant:** at most one non-head entry holds any given tag. The bench checks this with an assertion.
- **Coalesce (match):** write data into the matching entry's word, set its mask bit, overwrite any older value of that word. Pointers and count are unchanged.
- **Allocate (no match, not full):** write a new entry at tail with a one-hot mask and the other words zeroed. Tail advances modulo DEPTH.
- **Ready rule:** cache_req_ready = match || !full.
  - It never depends on mem_req_ready, so there is no combinational path memory→cache.
- **Dequeue:** when mem_req_valid && mem_req_ready, clear the head entry and advance head modulo DEPTH.
- **Count:** +1 on allocate only, −1 on dequeue only; unchanged when allocate and dequeue happen in the same cycle.
- **Head-line writes:** a write to the head entry's line when no other entry matches allocates a new entry. This holds even if the head is dequeued in the same cycle.
- **Forwarding:** search all occupied entries whose tag matches and whose mask bit for the word is set. Output the youngest (closest to tail); read_hit = read_check && any match.
- **Same-cycle write and read_check:** forwarding sees the pre-write state.
- **Reset:**
  - Clears all masks; head, tail and count become 0.
  - Outputs: cache_req_ready=1, mem_req_valid=0, mem_req_addr/data/mask=0, read_hit=0, read_data=0, count=0, empty=1, full=0.
  - Reset mid-operation discards all contents, including an unacknowledged head.

## Timing
- cache_req_ready, read_hit and read_data are combinational from current state and inputs. They are valid in the same cycle.
- An accepted write is visible to forwarding, count and mem outputs from the next cycle.
- An allocate into an empty buffer raises mem_req_valid one cycle after acceptance.
- mem_req_valid = !empty.
- mem_req_addr/data/mask stay stable while mem_req_valid && !mem_req_ready.
- Dequeue throughput: one entry per cycle.
- Peak occupancy change: +1/−1 per cycle.

## Structure
- **Package `wb_pkg`:**
  - Entry struct (tag, data array, mask).
  - Localparams TAG_W = ADDR_W − log2(WORDS) and PTR_W = log2(DEPTH).
  - Helper functions for tag and word-index extraction.
- **Sub-module `wb_line_match`:** parallel tag compare across all entries, producing:
  - a one-hot non-head write-match vector;
  - a youngest-first forwarding select relative to head.

## Test plan
- **Head not coalesced:** WORDS=4, mem_req_ready=0; write 0x100..0x103 with data 1..4 → count=2.
  - Entry0 mask 0001.
  - Entry1 mask 1110, data {4,3,2,0}.
- **Full:** 16 distinct lines with ready=0 → full=1.
  - New line 0x400 sees cache_req_ready=0.
  - A write to entry 5's line is accepted and count stays 16.
- **Forward youngest:** write 0x200=0xA, 0x204=0xB, 0x200=0xC.
  - read 0x200 → hit, 0xC.
  - read 0x201 → hit=0, data=0.
- **Backpressure:** hold ready=0 for 5 cycles → mem outputs constant. Then ready=1 for 1 cycle → count decrements and the next entry is presented.
- **Wrap:** 40 distinct lines with ready toggling every cycle → memory sees all 40 lines in order and count stays ≤ 16.
- **Reset mid-operation:** rst for one cycle at count=7 → next cycle empty=1, mem_req_valid=0, read_hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared geometry, entry layout and address helpers for the coalescing write buffer.
// The entry struct is sized from these constants, so top-level parameters must match them.
package wb_pkg;
    localparam int WB_DEPTH  = 16;
    localparam int WB_WORDS  = 4;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    localparam int WIDX_W = $clog2(WB_WORDS);
    localparam int TAG_W  = WB_ADDR_W - WIDX_W;
    localparam int PTR_W  = $clog2(WB_DEPTH);
    localparam int CNT_W  = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]                   tag;
        logic [WB_WORDS-1:0][WB_DATA_W-1:0] data;
        logic [WB_WORDS-1:0]                mask;
    } entry_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [WB_ADDR_W-1:0] addr);
        return addr[WB_ADDR_W-1:WIDX_W];
    endfunction

    function automatic logic [WIDX_W-1:0] word_of(input logic [WB_ADDR_W-1:0] addr);
        return addr[WIDX_W-1:0];
    endfunction
endpackage

// File: rtl/wb_line_match.sv
// Parallel tag compare over all entries, walked in age order starting from the head.
// Produces the non-head write match and the youngest forwarding hit for a read lookup.
module wb_line_match
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WORDS = WB_WORDS
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
    input  logic [DEPTH-1:0][WORDS-1:0] masks_i,
    input  logic [PTR_W-1:0]            head_i,
    input  logic [CNT_W-1:0]            count_i,
    input  logic [TAG_W-1:0]            wr_tag_i,
    input  logic [TAG_W-1:0]            rd_tag_i,
    input  logic [WIDX_W-1:0]           rd_word_i,
    output logic [DEPTH-1:0]            wr_match_o,
    output logic [PTR_W-1:0]            wr_idx_o,
    output logic                        fwd_hit_o,
    output logic [PTR_W-1:0]            fwd_idx_o
);
    logic [DEPTH-1:0][PTR_W-1:0] slot;
    logic [DEPTH-1:0]            occ;

    // slot[k] is the physical index of the entry of age k (0 = head)
    always_comb begin
        slot = '0;
        occ  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot[k] = head_i + PTR_W'(k);
            occ[k]  = CNT_W'(k) < count_i;
        end
    end

    // Later (younger) ages overwrite earlier hits, so the forward select ends on the youngest
    always_comb begin
        wr_match_o = '0;
        wr_idx_o   = '0;
        fwd_hit_o  = 1'b0;
        fwd_idx_o  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0 && occ[k] && tags_i[slot[k]] == wr_tag_i) begin
                wr_match_o[slot[k]] = 1'b1;
                wr_idx_o            = slot[k];
            end
            if (occ[k] && tags_i[slot[k]] == rd_tag_i && masks_i[slot[k]][rd_word_i]) begin
                fwd_hit_o = 1'b1;
                fwd_idx_o = slot[k];
            end
        end
    end
endmodule

// File: rtl/coalescing_write_buffer.sv
// Line-granular coalescing write buffer: merges cache word writes into queued lines,
// drains lines in FIFO order to memory and forwards the youngest buffered word to reads.
module coalescing_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int WORDS  = WB_WORDS,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cache_req_valid,
    output logic                       cache_req_ready,
    input  logic [ADDR_W-1:0]          cache_req_addr,
    input  logic [DATA_W-1:0]          cache_req_data,
    input  logic                       read_check,
    input  logic [ADDR_W-1:0]          read_addr,
    output logic                       read_hit,
    output logic [DATA_W-1:0]          read_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [WORDS*DATA_W-1:0]    mem_req_data,
    output logic [WORDS-1:0]           mem_req_mask,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    entry_t                      entries_q [DEPTH];
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic [DEPTH-1:0][WORDS-1:0] masks;
    logic [DEPTH-1:0]            wr_match;
    logic [PTR_W-1:0]            wr_idx, fwd_idx;
    logic                        wr_hit, fwd_hit, accept, alloc, coalesce, deq;
    logic [TAG_W-1:0]            wr_tag, rd_tag;
    logic [WIDX_W-1:0]           wr_word, rd_word;
    entry_t                      head_e, new_e;

    always_comb begin
        tags  = '0;
        masks = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tags[i]  = entries_q[i].tag;
            masks[i] = entries_q[i].mask;
        end
    end

    assign wr_tag  = tag_of(cache_req_addr);
    assign wr_word = word_of(cache_req_addr);
    assign rd_tag  = tag_of(read_addr);
    assign rd_word = word_of(read_addr);

    wb_line_match #(.DEPTH(DEPTH), .WORDS(WORDS)) u_match (
        .tags_i     (tags),
        .masks_i    (masks),
        .head_i     (head_q),
        .count_i    (count_q),
        .wr_tag_i   (wr_tag),
        .rd_tag_i   (rd_tag),
        .rd_word_i  (rd_word),
        .wr_match_o (wr_match),
        .wr_idx_o   (wr_idx),
        .fwd_hit_o  (fwd_hit),
        .fwd_idx_o  (fwd_idx)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready; ready on the
    // cache side depends only on buffer state and the offered address, never on mem_req_ready.
    assign wr_hit          = |wr_match;
    assign empty           = (count_q == '0);
    assign full            = (count_q == CNT_W'(DEPTH));
    assign count           = count_q;
    assign cache_req_ready = wr_hit || !full;
    assign accept          = cache_req_valid && cache_req_ready;
    assign alloc           = accept && !wr_hit;
    assign coalesce        = accept && wr_hit;
    assign mem_req_valid   = !empty;
    assign deq             = mem_req_valid && mem_req_ready;

    // Free slots are always zero, so the head entry alone drives quiet outputs when empty
    assign head_e       = entries_q[head_q];
    assign mem_req_addr = {head_e.tag, {WIDX_W{1'b0}}};
    assign mem_req_data = head_e.data;
    assign mem_req_mask = head_e.mask;

    assign read_hit  = read_check && fwd_hit;
    assign read_data = read_hit ? entries_q[fwd_idx].data[rd_word] : '0;

    always_comb begin
        new_e                = '0;
        new_e.tag            = wr_tag;
        new_e.data[wr_word]  = cache_req_data;
        new_e.mask[wr_word]  = 1'b1;
        head_d               = deq   ? head_q + PTR_W'(1) : head_q;
        tail_d               = alloc ? tail_q + PTR_W'(1) : tail_q;
        case ({alloc, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Coalesce never targets the head and allocate never lands on an occupied slot,
    // so the three entry updates below touch disjoint entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (deq) begin
                entries_q[head_q] <= '0;
            end
            if (alloc) begin
                entries_q[tail_q] <= new_e;
            end
            if (coalesce) begin
                entries_q[wr_idx].data[wr_word] <= cache_req_data;
                entries_q[wr_idx].mask[wr_word] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_coalescing_write_buffer.sv
// Bench for coalescing_write_buffer: vector table, directed corner sequences and a
// randomized phase checked against a queue-of-lines reference model.
module tb_coalescing_write_buffer;
    localparam int DEPTH = 16;
    localparam int WORDS = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic [29:0]         tag;
        logic [3:0][31:0]    data;
        logic [3:0]          mask;
    } mline_t;

    typedef struct {
        bit          do_rst;
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        rc;
        logic [31:0] ra;
        logic        mr;
        logic        e_rdy;
        logic        e_hit;
        logic [31:0] e_rd;
        int          e_cnt;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               cache_req_valid;
    logic               cache_req_ready;
    logic [AW-1:0]      cache_req_addr;
    logic [DW-1:0]      cache_req_data;
    logic               read_check;
    logic [AW-1:0]      read_addr;
    logic               read_hit;
    logic [DW-1:0]      read_data;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [AW-1:0]      mem_req_addr;
    logic [WORDS*DW-1:0] mem_req_data;
    logic [WORDS-1:0]   mem_req_mask;
    logic [4:0]         count;
    logic               empty;
    logic               full;

    mline_t      m_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_hs  = 0;

    logic         s_ready, s_hit, s_mvalid, s_empty, s_full;
    logic [31:0]  s_rdata, s_maddr;
    logic [127:0] s_mdata;
    logic [3:0]   s_mmask;
    logic [4:0]   s_count;

    coalescing_write_buffer #(.DEPTH(DEPTH), .WORDS(WORDS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cache_req_valid (cache_req_valid),
        .cache_req_ready (cache_req_ready),
        .cache_req_addr  (cache_req_addr),
        .cache_req_data  (cache_req_data),
        .read_check      (read_check),
        .read_addr       (read_addr),
        .read_hit        (read_hit),
        .read_data       (read_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_mask    (mem_req_mask),
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            assert ($onehot0(dut.wr_match)) else begin
                n_mis++;
                $display("FAIL wr_match_onehot: got %b required at most one bit set", dut.wr_match);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int find_nonhead(input logic [29:0] t);
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        cache_req_valid = 1'b1;
        cache_req_addr  = 32'h100;
        cache_req_data  = 32'hdead;
        read_check      = 1'b0;
        read_addr       = '0;
        mem_req_ready   = 1'b1;
        @(posedge clk);
        m_q.delete();
        exp_q.delete();
        n_hs = 0;
    endtask

    // driver + model check for one clock cycle
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic rc, input logic [31:0] ra, input logic mr);
        int          mi;
        int          pre_sz;
        logic        e_rdy, e_hit;
        logic [31:0] e_rd, e_addr;
        mline_t      hd, nl;
        @(negedge clk);
        rst             = 1'b0;
        cache_req_valid = v;
        cache_req_addr  = a;
        cache_req_data  = d;
        read_check      = rc;
        read_addr       = ra;
        mem_req_ready   = mr;
        #1;
        s_ready = cache_req_ready; s_hit = read_hit; s_rdata = read_data;
        s_mvalid = mem_req_valid; s_maddr = mem_req_addr; s_mdata = mem_req_data;
        s_mmask = mem_req_mask; s_count = count; s_empty = empty; s_full = full;

        pre_sz = m_q.size();
        mi     = find_nonhead(a[31:2]);
        e_rdy  = (mi >= 0) || (pre_sz < DEPTH);
        e_hit  = 1'b0;
        e_rd   = '0;
        if (rc) begin
            for (int i = pre_sz - 1; i >= 0; i--) begin
                if (m_q[i].tag == ra[31:2] && m_q[i].mask[ra[1:0]]) begin
                    e_hit = 1'b1;
                    e_rd  = m_q[i].data[ra[1:0]];
                    break;
                end
            end
        end
        hd = (pre_sz > 0) ? m_q[0] : '0;
        chk("cache_req_ready", 128'(s_ready), 128'(e_rdy));
        chk("read_hit", 128'(s_hit), 128'(e_hit));
        chk("read_data", 128'(s_rdata), 128'(e_rd));
        chk("mem_req_valid", 128'(s_mvalid), 128'(pre_sz > 0));
        chk("mem_req_addr", 128'(s_maddr), 128'({hd.tag, 2'b00}));
        chk("mem_req_data", s_mdata, hd.data);
        chk("mem_req_mask", 128'(s_mmask), 128'(hd.mask));
        chk("count", 128'(s_count), 128'(pre_sz));
        chk("empty", 128'(s_empty), 128'(pre_sz == 0));
        chk("full", 128'(s_full), 128'(pre_sz == DEPTH));

        // scoreboard: every handshake must carry the next line in allocation order
        if (s_mvalid && mr) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL mem_order: got line %0h required no transfer", s_maddr);
            end else begin
                e_addr = exp_q.pop_front();
                chk("mem_order", 128'(s_maddr), 128'(e_addr));
            end
        end

        @(posedge clk);
        if (v && e_rdy) begin
            if (mi >= 0) begin
                nl = m_q[mi];
                nl.data[a[1:0]] = d;
                nl.mask[a[1:0]] = 1'b1;
                m_q[mi] = nl;
            end else begin
                nl = '0;
                nl.tag = a[31:2];
                nl.data[a[1:0]] = d;
                nl.mask[a[1:0]] = 1'b1;
                m_q.push_back(nl);
                exp_q.push_back({a[31:2], 2'b00});
            end
        end
        if (pre_sz > 0 && mr) begin
            void'(m_q.pop_front());
        end
    endtask

    vec_t         tbl[12];
    logic [31:0]  b_addr;
    logic [127:0] b_data;
    logic [3:0]   b_mask;
    int           wi;

    initial begin
        rst = 1'b1; cache_req_valid = 1'b0; cache_req_addr = '0; cache_req_data = '0;
        read_check = 1'b0; read_addr = '0; mem_req_ready = 1'b0;

        tbl[0]  = '{1, 1, 32'h100, 32'h1, 0, 32'h0,   0, 1, 0, 32'h0, 0};
        tbl[1]  = '{0, 1, 32'h101, 32'h2, 0, 32'h0,   0, 1, 0, 32'h0, 1};
        tbl[2]  = '{0, 1, 32'h102, 32'h3, 1, 32'h101, 0, 1, 1, 32'h2, 2};
        tbl[3]  = '{0, 1, 32'h103, 32'h4, 1, 32'h102, 0, 1, 1, 32'h3, 2};
        tbl[4]  = '{0, 0, 32'h0,   32'h0, 1, 32'h100, 0, 1, 1, 32'h1, 2};
        tbl[5]  = '{0, 0, 32'h0,   32'h0, 1, 32'h103, 0, 1, 1, 32'h4, 2};
        tbl[6]  = '{0, 0, 32'h0,   32'h0, 1, 32'h104, 0, 1, 0, 32'h0, 2};
        tbl[7]  = '{1, 1, 32'h200, 32'hA, 0, 32'h0,   0, 1, 0, 32'h0, 0};
        tbl[8]  = '{0, 1, 32'h204, 32'hB, 0, 32'h0,   0, 1, 0, 32'h0, 1};
        tbl[9]  = '{0, 1, 32'h200, 32'hC, 1, 32'h200, 0, 1, 1, 32'hA, 2};
        tbl[10] = '{0, 0, 32'h0,   32'h0, 1, 32'h200, 0, 1, 1, 32'hC, 3};
        tbl[11] = '{0, 0, 32'h0,   32'h0, 1, 32'h201, 0, 1, 0, 32'h0, 3};

        // reset state
        do_reset();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk("rst_ready", 128'(s_ready), 128'(1));
        chk("rst_mvalid", 128'(s_mvalid), 128'(0));
        chk("rst_maddr", 128'(s_maddr), 128'(0));
        chk("rst_mdata", s_mdata, 128'(0));
        chk("rst_mmask", 128'(s_mmask), 128'(0));
        chk("rst_hit", 128'(s_hit), 128'(0));
        chk("rst_rdata", 128'(s_rdata), 128'(0));
        chk("rst_count", 128'(s_count), 128'(0));
        chk("rst_empty", 128'(s_empty), 128'(1));
        chk("rst_full", 128'(s_full), 128'(0));

        // table: head line not coalesced, then forward youngest
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_rst) do_reset();
            cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].rc, tbl[i].ra, tbl[i].mr);
            chk($sformatf("tbl%0d_ready", i), 128'(s_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_hit", i), 128'(s_hit), 128'(tbl[i].e_hit));
            chk($sformatf("tbl%0d_rdata", i), 128'(s_rdata), 128'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_count", i), 128'(s_count), 128'(tbl[i].e_cnt));
            if (i == 6) begin
                chk("head_entry0_addr", 128'(s_maddr), 128'(32'h100));
                chk("head_entry0_mask", 128'(s_mmask), 128'(4'b0001));
                chk("head_entry0_data", s_mdata, 128'h1);
                cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
                cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
                chk("entry1_count", 128'(s_count), 128'(1));
                chk("entry1_addr", 128'(s_maddr), 128'(32'h100));
                chk("entry1_mask", 128'(s_mmask), 128'(4'b1110));
                chk("entry1_data", s_mdata, 128'h00000004_00000003_00000002_00000000);
            end
        end

        // full buffer
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h1000 + 32'(i * 4), 32'(i + 1), 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h400, 32'h77, 1'b0, 32'h0, 1'b0);
        chk("full_flag", 128'(s_full), 128'(1));
        chk("full_new_line_ready", 128'(s_ready), 128'(0));
        cyc(1'b1, 32'h1016, 32'h55, 1'b0, 32'h0, 1'b0);
        chk("full_coalesce_ready", 128'(s_ready), 128'(1));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h1016, 1'b0);
        chk("full_count_kept", 128'(s_count), 128'(16));
        chk("full_coalesced_data", 128'(s_rdata), 128'(32'h55));

        // backpressure
        b_addr = s_maddr; b_data = s_mdata; b_mask = s_mmask;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("bp_addr_stable", 128'(s_maddr), 128'(b_addr));
            chk("bp_data_stable", s_mdata, b_data);
            chk("bp_mask_stable", 128'(s_mmask), 128'(b_mask));
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("bp_count_dec", 128'(s_count), 128'(15));
        chk("bp_next_addr", 128'(s_maddr), 128'(32'h1004));

        // wrap: 40 lines, memory ready toggling
        do_reset();
        wi = 0;
        for (int c = 0; c < 400; c++) begin
            cyc(wi < 40, 32'h2000 + 32'(wi * 4), 32'(wi), 1'b0, 32'h0, c[0]);
            chk("wrap_count_bound", 128'(s_count <= 5'd16), 128'(1));
            if (wi < 40 && s_ready) wi++;
            if (wi == 40 && n_hs == 40) break;
        end
        chk("wrap_lines_written", 128'(wi), 128'(40));
        chk("wrap_lines_seen", 128'(n_hs), 128'(40));

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h3000 + 32'(i * 4), 32'(i + 1), 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b0);
        chk("mid_count7", 128'(s_count), 128'(7));
        chk("mid_hit_before", 128'(s_hit), 128'(1));
        do_reset();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b0);
        chk("mid_empty", 128'(s_empty), 128'(1));
        chk("mid_mvalid", 128'(s_mvalid), 128'(0));
        chk("mid_hit_after", 128'(s_hit), 128'(0));

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pct;
            pct = ((c / 500) % 2 == 0) ? 25 : 75;
            cyc($urandom_range(0, 3) != 0, 32'h100 + 32'($urandom_range(0, 79)), $urandom,
                $urandom_range(0, 1) == 1, 32'h100 + 32'($urandom_range(0, 79)),
                $urandom_range(0, 99) < pct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
